// File: rtl/hs_pkg.sv
// hs_pkg: shared types and widths for the byte packing handshake stages.
package hs_pkg;
  localparam int DW_IN  = 8;
  localparam int DW_OUT = 16;
  localparam int KEEP_W = 2;
  typedef enum logic {ST_EMPTY, ST_HALF} state_t;
endpackage

// File: rtl/byte_packer_if.sv
// byte_packer_if: byte-in / word-out valid-ready bus of the byte packer.
interface byte_packer_if #(parameter int DW_IN = 8, parameter int DW_OUT = 16);
  logic [DW_IN-1:0]         data_i;
  logic                     valid_i;
  logic                     last_i;
  logic                     ready_o;
  logic [DW_OUT-1:0]        data_o;
  logic [DW_OUT/DW_IN-1:0]  keep_o;
  logic                     last_o;
  logic                     valid_o;
  logic                     ready_i;
  modport slave (input data_i, valid_i, last_i, ready_i, output ready_o, data_o, keep_o, last_o, valid_o);
  modport master (output data_i, valid_i, last_i, ready_i, input ready_o, data_o, keep_o, last_o, valid_o);
endinterface

// File: rtl/hs_slice.sv
// hs_slice: output register of a valid-ready stage; holds its word under backpressure.
module hs_slice #(
  parameter int W  = 16,
  parameter int KW = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [W-1:0]  d,
  input  logic [KW-1:0] k,
  input  logic          l,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output logic [KW-1:0] keep_o,
  output logic          last_o,
  output logic          ready_o
);
  assign ready_o = !valid_o || ready_i;
  // load only happens when ready_o was high, so a held word is never overwritten
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      keep_o  <= '0;
      last_o  <= 1'b0;
    end else if (load) begin
      valid_o <= 1'b1;
      data_o  <= d;
      keep_o  <= k;
      last_o  <= l;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
endmodule

// File: rtl/byte_packer.sv
// byte_packer: packs pairs of bytes into 16-bit words, flushing a lone byte on last.
module byte_packer #(
  parameter int DW_IN  = hs_pkg::DW_IN,
  parameter int DW_OUT = hs_pkg::DW_OUT
) (
  input  logic          clk,
  input  logic          rstn,
  byte_packer_if.slave  bus,
  output logic [15:0]   word_cnt_o
);
  import hs_pkg::*;
  state_t             state;
  logic [DW_IN-1:0]   lo_r;
  logic               accept;
  logic               issue;
  logic [DW_OUT-1:0]  word;
  logic [KEEP_W-1:0]  keep;
  logic               last;
  always_comb begin
    accept = bus.valid_i && bus.ready_o;
    issue  = accept && (state == ST_HALF || bus.last_i);
    word   = state == ST_HALF ? {bus.data_i, lo_r} : {{DW_IN{1'b0}}, bus.data_i};
    keep   = state == ST_HALF ? 2'b11 : 2'b01;
    last   = state == ST_HALF ? bus.last_i : 1'b1;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state      <= ST_EMPTY;
      lo_r       <= '0;
      word_cnt_o <= '0;
    end else begin
      if (accept && state == ST_EMPTY && !bus.last_i) begin
        state <= ST_HALF;
        lo_r  <= bus.data_i;
      end else if (accept) begin
        state <= ST_EMPTY;
      end
      if (bus.valid_o && bus.ready_i) word_cnt_o <= word_cnt_o + 16'd1;
    end
  hs_slice #(.W(DW_OUT), .KW(KEEP_W)) u_slice (
    .clk     (clk),
    .rstn    (rstn),
    .load    (issue),
    .d       (word),
    .k       (keep),
    .l       (last),
    .ready_i (bus.ready_i),
    .valid_o (bus.valid_o),
    .data_o  (bus.data_o),
    .keep_o  (bus.keep_o),
    .last_o  (bus.last_o),
    .ready_o (bus.ready_o)
  );
endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer: directed vector table plus reset, streaming and counter-wrap sequences.
module tb_byte_packer;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] word_cnt_o;
  int          n_vec = 0;
  int          n_err = 0;
  byte_packer_if #(.DW_IN(8), .DW_OUT(16)) bus ();
  byte_packer #(.DW_IN(8), .DW_OUT(16)) dut (.clk(clk), .rstn(rstn), .bus(bus), .word_cnt_o(word_cnt_o));
  always #5 clk = ~clk;
  typedef struct {
    logic v, l, r;
    logic [7:0] d;
    logic ev, er, el;
    logic [1:0] ek;
    logic [15:0] ed, ec;
  } vec_t;
  vec_t vq[$];
  function automatic vec_t mk(logic v, logic l, logic [7:0] d, logic r, logic ev, logic er,
                              logic el, logic [1:0] ek, logic [15:0] ed, logic [15:0] ec);
    vec_t x;
    x.v = v; x.l = l; x.d = d; x.r = r;
    x.ev = ev; x.er = er; x.el = el; x.ek = ek; x.ed = ed; x.ec = ec;
    return x;
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] outs(logic masked);
    return {27'd0, bus.valid_o, bus.ready_o, masked ? 1'b0 : bus.last_o,
            masked ? 2'b00 : bus.keep_o, masked ? 16'h0 : bus.data_o, word_cnt_o};
  endfunction
  task automatic drive(logic v, logic l, logic [7:0] d, logic r);
    @(negedge clk);
    bus.valid_i = v; bus.last_i = l; bus.data_i = d; bus.ready_i = r;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    bus.valid_i = 1'b0; bus.last_i = 1'b0; bus.ready_i = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask
  initial begin
    bus.valid_i = 1'b0; bus.last_i = 1'b0; bus.data_i = 8'h00; bus.ready_i = 1'b1;
    vq.push_back(mk(1,0,8'h11,1, 0,1,0,2'd0,16'h0000,16'd0));
    vq.push_back(mk(1,1,8'h22,1, 0,1,0,2'd0,16'h0000,16'd0));
    vq.push_back(mk(0,0,8'h00,1, 1,1,1,2'd3,16'h2211,16'd0));
    vq.push_back(mk(1,1,8'hA5,1, 0,1,0,2'd0,16'h0000,16'd1));
    vq.push_back(mk(0,0,8'h00,1, 1,1,1,2'd1,16'h00A5,16'd1));
    vq.push_back(mk(1,0,8'h01,1, 0,1,0,2'd0,16'h0000,16'd2));
    vq.push_back(mk(1,0,8'h02,0, 0,1,0,2'd0,16'h0000,16'd2));
    vq.push_back(mk(1,0,8'h03,0, 1,0,0,2'd3,16'h0201,16'd2));
    vq.push_back(mk(1,0,8'h03,0, 1,0,0,2'd3,16'h0201,16'd2));
    vq.push_back(mk(1,0,8'h03,0, 1,0,0,2'd3,16'h0201,16'd2));
    vq.push_back(mk(1,0,8'h03,1, 1,1,0,2'd3,16'h0201,16'd2));
    vq.push_back(mk(1,0,8'h04,1, 0,1,0,2'd0,16'h0000,16'd3));
    vq.push_back(mk(1,0,8'h05,1, 1,1,0,2'd3,16'h0403,16'd3));
    vq.push_back(mk(1,1,8'h06,1, 0,1,0,2'd0,16'h0000,16'd4));
    vq.push_back(mk(0,0,8'h00,1, 1,1,1,2'd3,16'h0605,16'd4));
    vq.push_back(mk(0,0,8'h00,1, 0,1,0,2'd0,16'h0000,16'd5));
    vq.push_back(mk(1,1,8'hB6,1, 0,1,0,2'd0,16'h0000,16'd5));
    vq.push_back(mk(1,1,8'hC7,1, 1,1,1,2'd1,16'h00B6,16'd5));
    vq.push_back(mk(0,0,8'h00,1, 1,1,1,2'd1,16'h00C7,16'd6));
    vq.push_back(mk(0,0,8'h00,1, 0,1,0,2'd0,16'h0000,16'd7));
    #2;
    chk("reset_state", outs(1'b0), {27'd0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0, 16'h0});
    @(negedge clk);
    rstn = 1'b1;
    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].l, vq[i].d, vq[i].r);
      chk($sformatf("vec%0d", i), outs(!vq[i].ev),
          {27'd0, vq[i].ev, vq[i].er, vq[i].el, vq[i].ek, vq[i].ed, vq[i].ec});
    end
    // reset while a low byte is held must drop it, asynchronously
    drive(1, 0, 8'h33, 1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    rstn = 1'b0;
    #1;
    chk("async_reset", outs(1'b0), {27'd0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0, 16'h0});
    @(negedge clk);
    rstn = 1'b1;
    drive(1, 0, 8'h44, 1);
    drive(1, 1, 8'h55, 1);
    drive(0, 0, 8'h00, 1);
    chk("after_reset_word", outs(1'b0), {27'd0, 1'b1, 1'b1, 1'b1, 2'b11, 16'h5544, 16'h0});
    begin
      int nw = 0, bubbles = 0, derr = 0;
      do_reset();
      for (int k = 0; k < 34; k++) begin
        drive(k < 32, k == 31, 8'(k + 1), 1);
        if (k < 32 && !bus.ready_o) bubbles++;
        if (bus.valid_o) begin
          if (bus.data_o !== {8'(2 * nw + 2), 8'(2 * nw + 1)} || bus.keep_o !== 2'b11 || bus.last_o !== (nw == 15))
            derr++;
          nw++;
        end
      end
      chk("stream_words", 64'(nw), 64'd16);
      chk("stream_bubbles", 64'(bubbles), 64'd0);
      chk("stream_data", 64'(derr), 64'd0);
      chk("stream_cnt", 64'(word_cnt_o), 64'd16);
    end
    begin
      int uerr = 0, bubbles = 0;
      do_reset();
      for (int k = 0; k < 65535; k++) begin
        drive(1, 1, 8'(k ^ 8'h5A), 1);
        if (!bus.ready_o) bubbles++;
        if (bus.valid_o && (bus.data_o[15:8] !== 8'h00 || bus.keep_o !== 2'b01)) uerr++;
      end
      drive(0, 0, 8'h00, 1);
      drive(0, 0, 8'h00, 1);
      chk("wrap_ffff", 64'(word_cnt_o), 64'hFFFF);
      drive(1, 1, 8'h99, 1);
      drive(0, 0, 8'h00, 1);
      chk("single_word", outs(1'b0), {27'd0, 1'b1, 1'b1, 1'b1, 2'b01, 16'h0099, 16'hFFFF});
      drive(0, 0, 8'h00, 1);
      chk("wrap_zero", 64'(word_cnt_o), 64'h0);
      chk("single_upper_zero", 64'(uerr), 64'd0);
      chk("single_bubbles", 64'(bubbles), 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
